// File: rtl/tow_pkg.sv
// ---------------------------------------------------------------------------
// tow_pkg
// Shared definitions for the tug-of-war game engine.
//   tow_state_e   : game phases walked by tow_core
//   tow_side_e    : which player a point or match belongs to (LEFT = 1)
//   LFSR_TAPS_*   : Galois feedback masks for the supported random widths
//   BLINK_PERIOD  : POINT display blink period in ticks (half on, half off)
//   lfsr_taps()   : picks the feedback mask for a given LFSR width
// ---------------------------------------------------------------------------
package tow_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      PLAY,
      POINT,
      MATCH_OVER
   } tow_state_e;

   typedef enum logic {
      RIGHT = 1'b0,
      LEFT  = 1'b1
   } tow_side_e;

   // Right-shifting Galois form: bit (e-1) is set for every term x^e, e > 0.
   // x^8 + x^6 + x^5 + x^4 + 1
   localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
   // x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

   localparam int BLINK_PERIOD = 16;

   function automatic logic [15:0] lfsr_taps(input int width);
      return (width == 16) ? LFSR_TAPS_16 : {8'h00, LFSR_TAPS_8};
   endfunction

endpackage

// File: rtl/tow_lfsr.sv
// ---------------------------------------------------------------------------
// tow_lfsr
// Free-running maximal-length Galois LFSR used to randomise the ARM delay.
// Advances every clock; the all-ones seed guarantees it never sits at zero.
// Ports:
//   clk    in  : clock
//   rst_n  in  : asynchronous active-low reset (loads all-ones)
//   value  out : current LFSR state, LFSR_W bits (8 or 16)
// ---------------------------------------------------------------------------
module tow_lfsr
   import tow_pkg::*;
#(
   parameter int LFSR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [LFSR_W-1:0] value
);

   localparam logic [15:0]       TAPS_FULL = lfsr_taps(LFSR_W);
   localparam logic [LFSR_W-1:0] TAPS      = TAPS_FULL[LFSR_W-1:0];

   // Shift right every clock; when a one falls out of bit 0 the feedback
   // mask is folded back in, which is the Galois form of the polynomial.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '1;
      end else if (value[0]) begin
         value <= (value >> 1) ^ TAPS;
      end else begin
         value <= value >> 1;
      end
   end

endmodule

// File: rtl/tow_core.sv
// ---------------------------------------------------------------------------
// tow_core
// Tug-of-war game engine: randomised "get ready" delay with false-start
// detection, rope position over NUM_LEDS LEDs, and a best-of-N match score.
// Ports:
//   CLK_I      in  : game clock
//   rst        in  : asynchronous active-low reset
//   tick       in  : one-cycle game-rate enable
//   pbl, pbr   in  : synchronised left / right button levels
//   start      in  : one-cycle pulse, starts or restarts the match
//   Led        out : LED drive, bit NUM_LEDS-1 is the leftmost LED
//   score_l/r  out : per-player score, saturating at ROUNDS_TO_WIN
//   match_over out : high while the match result is shown
//   winner     out : 1 = left, 0 = right; meaningful while match_over
// ---------------------------------------------------------------------------
module tow_core
   import tow_pkg::*;
#(
   parameter int NUM_LEDS      = 7,
   parameter int ROUNDS_TO_WIN = 3,
   parameter int ARM_MIN       = 64,
   parameter int LFSR_W        = 8,
   parameter int POINT_TICKS   = 128
) (
   input  logic                               CLK_I,
   input  logic                               rst,
   input  logic                               tick,
   input  logic                               pbl,
   input  logic                               pbr,
   input  logic                               start,
   output logic [NUM_LEDS-1:0]                Led,
   output logic [$clog2(ROUNDS_TO_WIN+1)-1:0] score_l,
   output logic [$clog2(ROUNDS_TO_WIN+1)-1:0] score_r,
   output logic                               match_over,
   output logic                               winner
);

   localparam int CENTER  = (NUM_LEDS - 1) / 2;
   localparam int POS_W   = $clog2(NUM_LEDS);
   localparam int CNT_W   = $clog2(ARM_MIN + (1 << LFSR_W));
   localparam int PT_W    = $clog2(POINT_TICKS);
   localparam int SCORE_W = $clog2(ROUNDS_TO_WIN + 1);

   localparam logic [NUM_LEDS-1:0] LEFT_HALF  = {{(CENTER+1){1'b1}}, {CENTER{1'b0}}};
   localparam logic [NUM_LEDS-1:0] RIGHT_HALF = {{CENTER{1'b0}}, {(CENTER+1){1'b1}}};

   tow_state_e          state_q, state_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic [CNT_W-1:0]    arm_cnt_q, arm_cnt_d;
   logic [PT_W-1:0]     pt_cnt_q, pt_cnt_d;
   logic [SCORE_W-1:0]  score_l_q, score_l_d;
   logic [SCORE_W-1:0]  score_r_q, score_r_d;
   tow_side_e           scorer_q, scorer_d;
   tow_side_e           winner_q, winner_d;
   logic [NUM_LEDS-1:0] led_q, led_d;
   logic                pbl_q, pbr_q;

   logic                edge_l, edge_r;
   logic                award_l, award_r;
   logic                blink_on;
   logic [LFSR_W-1:0]   lfsr_value;
   logic [CNT_W-1:0]    arm_load;

   tow_lfsr #(
      .LFSR_W (LFSR_W)
   ) u_lfsr (
      .clk   (CLK_I),
      .rst_n (rst),
      .value (lfsr_value)
   );

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (s == SCORE_W'(ROUNDS_TO_WIN)) ? s : s + SCORE_W'(1);
   endfunction

   assign edge_l   = pbl & ~pbl_q;
   assign edge_r   = pbr & ~pbr_q;
   assign arm_load = CNT_W'(ARM_MIN) + CNT_W'(lfsr_value);
   assign blink_on = (32'(pt_cnt_q) % 32'(BLINK_PERIOD)) < 32'(BLINK_PERIOD / 2);

   // All game state lives here; every register reloads its reset value the
   // moment rst drops so no partial score survives a mid-game reset.
   always_ff @(posedge CLK_I or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         pos_q     <= POS_W'(CENTER);
         arm_cnt_q <= '0;
         pt_cnt_q  <= '0;
         score_l_q <= '0;
         score_r_q <= '0;
         scorer_q  <= RIGHT;
         winner_q  <= RIGHT;
         led_q     <= '0;
         pbl_q     <= 1'b0;
         pbr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         arm_cnt_q <= arm_cnt_d;
         pt_cnt_q  <= pt_cnt_d;
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
         scorer_q  <= scorer_d;
         winner_q  <= winner_d;
         led_q     <= led_d;
         pbl_q     <= pbl;
         pbr_q     <= pbr;
      end
   end

   // Next-state logic. Phases only raise award_l/award_r; the shared block at
   // the end turns a point into a score bump plus entry into POINT, so a
   // false start in ARM and a rope reaching an end in PLAY behave the same.
   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      arm_cnt_d = arm_cnt_q;
      pt_cnt_d  = pt_cnt_q;
      score_l_d = score_l_q;
      score_r_d = score_r_q;
      scorer_d  = scorer_q;
      winner_d  = winner_q;
      award_l   = 1'b0;
      award_r   = 1'b0;

      case (state_q)
         IDLE, MATCH_OVER: begin
            if (start) begin
               state_d   = ARM;
               arm_cnt_d = arm_load;
               score_l_d = '0;
               score_r_d = '0;
            end
         end

         ARM: begin
            // Button checks come before the tick so a false start on the
            // last countdown tick still wins over entering PLAY.
            if (edge_l && edge_r) begin
               arm_cnt_d = arm_load;
            end else if (edge_l) begin
               award_r = 1'b1;
            end else if (edge_r) begin
               award_l = 1'b1;
            end else if (tick) begin
               arm_cnt_d = arm_cnt_q - CNT_W'(1);
               if (arm_cnt_q == CNT_W'(1)) begin
                  state_d = PLAY;
                  pos_d   = POS_W'(CENTER);
               end
            end
         end

         PLAY: begin
            if (edge_l && !edge_r) begin
               pos_d = pos_q + POS_W'(1);
               if (pos_q == POS_W'(NUM_LEDS - 2)) begin
                  award_l = 1'b1;
               end
            end else if (edge_r && !edge_l) begin
               pos_d = pos_q - POS_W'(1);
               if (pos_q == POS_W'(1)) begin
                  award_r = 1'b1;
               end
            end
         end

         POINT: begin
            if (tick) begin
               if (pt_cnt_q == PT_W'(POINT_TICKS - 1)) begin
                  if (((scorer_q == LEFT) ? score_l_q : score_r_q) == SCORE_W'(ROUNDS_TO_WIN)) begin
                     state_d  = MATCH_OVER;
                     winner_d = scorer_q;
                  end else begin
                     state_d   = ARM;
                     arm_cnt_d = arm_load;
                  end
               end else begin
                  pt_cnt_d = pt_cnt_q + PT_W'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (award_l) begin
         score_l_d = sat_inc(score_l_q);
         scorer_d  = LEFT;
         state_d   = POINT;
         pt_cnt_d  = '0;
      end
      if (award_r) begin
         score_r_d = sat_inc(score_r_q);
         scorer_d  = RIGHT;
         state_d   = POINT;
         pt_cnt_d  = '0;
      end
   end

   // LED image decoded from the current state and registered, which puts the
   // LEDs one clock behind the position/state update.
   always_comb begin
      led_d = '0;
      case (state_q)
         PLAY: begin
            led_d = NUM_LEDS'(1) << pos_q;
         end
         POINT: begin
            if (blink_on) begin
               led_d = (scorer_q == LEFT) ? (NUM_LEDS'(1) << (NUM_LEDS - 1)) : NUM_LEDS'(1);
            end
         end
         MATCH_OVER: begin
            led_d = (winner_q == LEFT) ? LEFT_HALF : RIGHT_HALF;
         end
         default: begin
            led_d = '0;
         end
      endcase
   end

   assign Led        = led_q;
   assign score_l    = score_l_q;
   assign score_r    = score_r_q;
   assign match_over = (state_q == MATCH_OVER);
   assign winner     = winner_q;

endmodule

// File: tb/tb_tow_core.sv
// ---------------------------------------------------------------------------
// tb_tow_core
// Randomised bench for tow_core. A reference game, advanced once per clock by
// the stimulus task, pushes the expected outputs into a queue; a monitor pops
// one entry per clock and compares it with what the DUT shows.
// ---------------------------------------------------------------------------
module tb_tow_core;

   parameter int NUM_LEDS      = 7;
   parameter int ROUNDS_TO_WIN = 3;
   parameter int ARM_MIN       = 64;
   parameter int LFSR_W        = 8;
   parameter int POINT_TICKS   = 128;

   localparam int CENTER  = (NUM_LEDS - 1) / 2;
   localparam int SCORE_W = $clog2(ROUNDS_TO_WIN + 1);

   localparam int PH_IDLE  = 0;
   localparam int PH_ARM   = 1;
   localparam int PH_PLAY  = 2;
   localparam int PH_POINT = 3;
   localparam int PH_OVER  = 4;

   logic                clk   = 1'b0;
   logic                rst   = 1'b1;
   logic                tick  = 1'b0;
   logic                pbl   = 1'b0;
   logic                pbr   = 1'b0;
   logic                start = 1'b0;
   logic [NUM_LEDS-1:0] led;
   logic [SCORE_W-1:0]  score_l;
   logic [SCORE_W-1:0]  score_r;
   logic                match_over;
   logic                winner;

   tow_core #(
      .NUM_LEDS      (NUM_LEDS),
      .ROUNDS_TO_WIN (ROUNDS_TO_WIN),
      .ARM_MIN       (ARM_MIN),
      .LFSR_W        (LFSR_W),
      .POINT_TICKS   (POINT_TICKS)
   ) dut (
      .CLK_I      (clk),
      .rst        (rst),
      .tick       (tick),
      .pbl        (pbl),
      .pbr        (pbr),
      .start      (start),
      .Led        (led),
      .score_l    (score_l),
      .score_r    (score_r),
      .match_over (match_over),
      .winner     (winner)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NUM_LEDS-1:0] led;
      int                  sl;
      int                  sr;
      bit                  over;
      bit                  win;
   } expect_t;

   expect_t exp_q[$];
   expect_t mon_e;

   int checks      = 0;
   int errors      = 0;
   int fail_prints = 0;
   bit tick_always = 1'b0;

   // Reference game state
   int m_phase;
   int m_pos;
   int m_left;
   int m_right;
   int m_ticks_left;
   int m_point_ticks;
   bit m_scorer_left;
   bit m_winner_left;
   bit m_prev_l;
   bit m_prev_r;
   int m_lfsr;

   // One comparison; failures are always counted, printing is capped.
   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         if (fail_prints < 40) begin
            fail_prints++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
         end
      end
   endtask

   // Next LFSR value, built from the polynomial's exponent list.
   function automatic int lfsr_next(input int v);
      int exps[$];
      int mask;
      mask = 0;
      if (LFSR_W == 16) exps = '{16, 14, 13, 11};
      else              exps = '{8, 6, 5, 4};
      foreach (exps[i]) mask |= (1 << (exps[i] - 1));
      return ((v & 1) != 0) ? ((v >> 1) ^ mask) : (v >> 1);
   endfunction

   function automatic bit rand_tick();
      return tick_always ? 1'b1 : ($urandom_range(0, 3) != 0);
   endfunction

   // What the LEDs should show for the reference game's current phase.
   function automatic logic [NUM_LEDS-1:0] model_led();
      logic [NUM_LEDS-1:0] v;
      v = '0;
      case (m_phase)
         PH_PLAY:  v[m_pos] = 1'b1;
         PH_POINT: if (((m_point_ticks / 8) % 2) == 0) v[m_scorer_left ? NUM_LEDS - 1 : 0] = 1'b1;
         PH_OVER:  for (int i = 0; i < NUM_LEDS; i++)
                      if (m_winner_left ? (i >= CENTER) : (i <= CENTER)) v[i] = 1'b1;
         default:  v = '0;
      endcase
      return v;
   endfunction

   function automatic void model_award(input bit left);
      if (left) m_left  = (m_left  < ROUNDS_TO_WIN) ? m_left  + 1 : m_left;
      else      m_right = (m_right < ROUNDS_TO_WIN) ? m_right + 1 : m_right;
      m_scorer_left = left;
      m_phase       = PH_POINT;
      m_point_ticks = 0;
   endfunction

   function automatic void model_arm(input bit clear_scores);
      m_phase      = PH_ARM;
      m_ticks_left = ARM_MIN + m_lfsr;
      if (clear_scores) begin
         m_left  = 0;
         m_right = 0;
      end
   endfunction

   // Drive one clock of inputs, advance the reference game by that clock and
   // queue what the DUT must show right after the coming edge. The LEDs lag
   // one clock, so they take the image of the game before this update.
   task automatic applyStimulus(input bit t, input bit l, input bit r, input bit s);
      bit      el;
      bit      er;
      expect_t e;
      tick  = t;
      pbl   = l;
      pbr   = r;
      start = s;
      el = l && !m_prev_l;
      er = r && !m_prev_r;
      e.led = model_led();
      case (m_phase)
         PH_IDLE: if (s) model_arm(1'b1);
         PH_ARM: begin
            if (el && er) m_ticks_left = ARM_MIN + m_lfsr;
            else if (el || er) model_award(er);
            else if (t) begin
               m_ticks_left--;
               if (m_ticks_left == 0) begin
                  m_phase = PH_PLAY;
                  m_pos   = CENTER;
               end
            end
         end
         PH_PLAY: begin
            if (el != er) begin
               m_pos += el ? 1 : -1;
               if (m_pos == NUM_LEDS - 1) model_award(1'b1);
               else if (m_pos == 0)       model_award(1'b0);
            end
         end
         PH_POINT: begin
            if (t) begin
               m_point_ticks++;
               if (m_point_ticks == POINT_TICKS) begin
                  if ((m_scorer_left ? m_left : m_right) == ROUNDS_TO_WIN) begin
                     m_phase       = PH_OVER;
                     m_winner_left = m_scorer_left;
                  end else begin
                     model_arm(1'b0);
                  end
               end
            end
         end
         PH_OVER: if (s) model_arm(1'b1);
         default: m_phase = PH_IDLE;
      endcase
      e.sl   = m_left;
      e.sr   = m_right;
      e.over = (m_phase == PH_OVER);
      e.win  = m_winner_left;
      exp_q.push_back(e);
      m_lfsr   = lfsr_next(m_lfsr);
      m_prev_l = l;
      m_prev_r = r;
      @(posedge clk);
      #3;
   endtask

   // Asynchronous reset: outputs must clear before any clock edge arrives.
   task automatic applyReset();
      rst   = 1'b0;
      tick  = 1'b0;
      pbl   = 1'b0;
      pbr   = 1'b0;
      start = 1'b0;
      exp_q.delete();
      #1;
      checkOutput("reset_led", led, 0);
      checkOutput("reset_score_l", score_l, 0);
      checkOutput("reset_score_r", score_r, 0);
      checkOutput("reset_match_over", match_over, 0);
      checkOutput("reset_winner", winner, 0);
      @(posedge clk);
      #3;
      m_phase       = PH_IDLE;
      m_pos         = CENTER;
      m_left        = 0;
      m_right       = 0;
      m_ticks_left  = 0;
      m_point_ticks = 0;
      m_scorer_left = 1'b0;
      m_winner_left = 1'b0;
      m_prev_l      = 1'b0;
      m_prev_r      = 1'b0;
      m_lfsr        = (1 << LFSR_W) - 1;
      rst           = 1'b1;
   endtask

   task automatic waitPhase(input int target, input int budget);
      int n;
      n = 0;
      while (m_phase != target && n < budget) begin
         applyStimulus(rand_tick(), 1'b0, 1'b0, 1'b0);
         n++;
      end
      if (m_phase != target) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_phase: reached phase %0d, required %0d", m_phase, target);
      end
   endtask

   task automatic press(input bit l, input bit r);
      applyStimulus(rand_tick(), l, r, 1'b0);
      applyStimulus(rand_tick(), 1'b0, 1'b0, 1'b0);
   endtask

   // Random play until the match ends: busy buttons in PLAY, rare false
   // starts in ARM, noise (including stray start pulses) elsewhere.
   task automatic playMatch(input int budget);
      int n;
      n = 0;
      while (m_phase != PH_OVER && n < budget) begin
         case (m_phase)
            PH_PLAY: applyStimulus(rand_tick(), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                                   $urandom_range(0, 49) == 0);
            PH_ARM:  applyStimulus(rand_tick(), $urandom_range(0, 299) == 0, $urandom_range(0, 299) == 0,
                                   $urandom_range(0, 49) == 0);
            default: applyStimulus(rand_tick(), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                                   $urandom_range(0, 49) == 0);
         endcase
         n++;
      end
      if (m_phase != PH_OVER) begin
         checks++;
         errors++;
         $display("[TB] FAIL match_end: reached phase %0d within %0d cycles", m_phase, budget);
      end
   endtask

   // Monitor: one queued expectation per clock, sampled just after the edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         checkOutput("led", led, mon_e.led);
         checkOutput("score_l", score_l, mon_e.sl);
         checkOutput("score_r", score_r, mon_e.sr);
         checkOutput("match_over", match_over, mon_e.over);
         if (mon_e.over) checkOutput("winner", winner, mon_e.win);
      end
   end

   initial begin
      #2;
      applyReset();

      // Buttons and ticks in IDLE do nothing.
      repeat (6) applyStimulus(rand_tick(), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0);
      applyStimulus(rand_tick(), 1'b0, 1'b0, 1'b0);

      // Quiet start into PLAY, then walk the rope to the left end.
      applyStimulus(rand_tick(), 1'b0, 1'b0, 1'b1);
      waitPhase(PH_PLAY, 2000);
      repeat (3) applyStimulus(rand_tick(), 1'b0, 1'b0, 1'b0);
      repeat (3) press(1'b1, 1'b0);
      waitPhase(PH_ARM, 1000);

      // Right false start gives left a point; then a double edge reloads.
      repeat (3) applyStimulus(rand_tick(), 1'b0, 1'b0, 1'b0);
      press(1'b0, 1'b1);
      waitPhase(PH_ARM, 1000);
      repeat (10) applyStimulus(rand_tick(), 1'b0, 1'b0, 1'b0);
      press(1'b1, 1'b1);
      waitPhase(PH_PLAY, 2000);

      // Simultaneous edges in PLAY leave the rope where it is.
      press(1'b1, 1'b1);
      press(1'b1, 1'b1);
      press(1'b0, 1'b1);

      // Finish the match randomly, linger, then restart.
      playMatch(30000);
      repeat (5) applyStimulus(rand_tick(), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0);
      applyStimulus(rand_tick(), 1'b0, 1'b0, 1'b1);

      // Second match with tick every clock.
      tick_always = 1'b1;
      playMatch(30000);
      tick_always = 1'b0;
      applyStimulus(rand_tick(), 1'b0, 1'b0, 1'b1);

      // Reset in the middle of PLAY, then a fresh game.
      waitPhase(PH_PLAY, 2000);
      press(1'b1, 1'b0);
      applyReset();
      repeat (4) applyStimulus(rand_tick(), 1'b0, 1'b0, 1'b0);
      applyStimulus(rand_tick(), 1'b0, 1'b0, 1'b1);
      waitPhase(PH_PLAY, 2000);
      repeat (4) applyStimulus(rand_tick(), 1'b0, 1'b0, 1'b0);

      @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
